// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller.
package pipe_ctrl_pkg;

  localparam int unsigned NREG   = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 16;
  localparam int unsigned IDX_W  = 3;

  // Inter-stage register indices
  localparam int unsigned R_IFID  = 0;
  localparam int unsigned R_IDRR  = 1;
  localparam int unsigned R_RREX  = 2;
  localparam int unsigned R_EXMEM = 3;
  localparam int unsigned R_MEMWB = 4;

  // Branch redirect squashes IF/ID, ID/RR, RR/EX; load-use inserts a bubble at RR/EX
  localparam logic [NREG-1:0] FLUSH_BR = 5'b00111;
  localparam logic [NREG-1:0] FLUSH_LU = 5'b00100;

  // Largest legal LM/SM register count
  localparam logic [CNT_W-1:0] MULTI_MAX = CNT_W'(8);

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  // Clamp an LM/SM count to the legal range
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c > MULTI_MAX) ? MULTI_MAX : c;
  endfunction

endpackage

// File: rtl/multi_seq.sv
// LM/SM micro-op sequencer: remaining-count down-counter and micro-op index.
module multi_seq
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] idx
);

  // Load starts after micro-op 0 has issued, so index begins at 1; no control means hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      idx   <= '0;
    end else if (clear) begin
      count <= '0;
      idx   <= '0;
    end else if (load) begin
      count <= CNT_W'(load_val - CNT_W'(1));
      idx   <= IDX_W'(1);
    end else if (step) begin
      count <= CNT_W'(count - CNT_W'(1));
      idx   <= IDX_W'(idx + IDX_W'(1));
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencing controller: merges memory freeze, branch redirect,
// load-use bubble and LM/SM multi-cycle issue into one control vector.
// Optional performance counters enabled by macro PIPE_STAGE_CTRL_PERF_EN.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_busy,
  input  logic             br_flush,
  input  logic             ld_use_haz,
  input  logic             multi_req,
  input  logic [CNT_W-1:0] multi_cnt,
  output logic             pc_we,
  output logic [NREG-1:0]  stage_en,
  output logic [NREG-1:0]  stage_flush,
  output logic [IDX_W-1:0] multi_idx,
  output logic             multi_busy
`ifdef PIPE_STAGE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
`endif
);

  state_t           state, nxt_state;
  logic             seq_clear, seq_load, seq_step;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_sat;

  assign cnt_sat    = sat_cnt(multi_cnt);
  assign multi_busy = (state == MULTI);

  multi_seq u_multi_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (seq_clear),
    .load     (seq_load),
    .load_val (cnt_sat),
    .step     (seq_step),
    .count    (count),
    .idx      (multi_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= nxt_state;
  end

  // Priority resolution: mem_busy > br_flush > ld_use_haz > multi issue
  always_comb begin
    nxt_state   = state;
    pc_we       = 1'b1;
    stage_en    = '1;
    stage_flush = '0;
    seq_clear   = 1'b0;
    seq_load    = 1'b0;
    seq_step    = 1'b0;
    if (mem_busy) begin
      pc_we    = 1'b0;
      stage_en = '0;
    end else if (br_flush) begin
      stage_flush = FLUSH_BR;
      nxt_state   = RUN;
      seq_clear   = 1'b1;
    end else if (ld_use_haz) begin
      pc_we            = 1'b0;
      stage_en[R_IFID] = 1'b0;
      stage_en[R_IDRR] = 1'b0;
      stage_flush      = FLUSH_LU;
    end else if (state == MULTI) begin
      if (count > CNT_W'(1)) begin
        pc_we            = 1'b0;
        stage_en[R_IFID] = 1'b0;
        seq_step         = 1'b1;
      end else begin
        nxt_state = RUN;
        seq_clear = 1'b1;
      end
    end else if (multi_req && (cnt_sat >= CNT_W'(2))) begin
      pc_we            = 1'b0;
      stage_en[R_IFID] = 1'b0;
      nxt_state        = MULTI;
      seq_load         = 1'b1;
    end
    // Reset forces a safe control vector straight through to the outputs
    if (!rst) begin
      pc_we       = 1'b0;
      stage_en    = '0;
      stage_flush = '1;
    end
  end

`ifdef PIPE_STAGE_CTRL_PERF_EN
  // Stall-cycle and redirect-event counters, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_we)
        stall_cycles <= PERF_W'(stall_cycles + PERF_W'(1));
      if (br_flush && !mem_busy)
        flush_events <= PERF_W'(flush_events + PERF_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: stimulus pushes expected control
// vectors, a negedge monitor pops and compares.
module tb_pipe_stage_ctrl;

  typedef struct packed {
    logic       pc;
    logic [4:0] en;
    logic [4:0] fl;
    logic [2:0] idx;
    logic       busy;
  } exp_t;

  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_MUL = 5'b11110;
  localparam logic [4:0] EN_LU  = 5'b11100;
  localparam logic [4:0] EN_0   = 5'b00000;
  localparam logic [4:0] FL_0   = 5'b00000;
  localparam logic [4:0] FL_BR  = 5'b00111;
  localparam logic [4:0] FL_LU  = 5'b00100;
  localparam logic [4:0] FL_RST = 5'b11111;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_busy, br_flush, ld_use_haz, multi_req;
  logic [3:0] multi_cnt;
  logic       pc_we;
  logic [4:0] stage_en, stage_flush;
  logic [2:0] multi_idx;
  logic       multi_busy;
`ifdef PIPE_STAGE_CTRL_PERF_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_no = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  pipe_stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_busy    (mem_busy),
    .br_flush    (br_flush),
    .ld_use_haz  (ld_use_haz),
    .multi_req   (multi_req),
    .multi_cnt   (multi_cnt),
    .pc_we       (pc_we),
    .stage_en    (stage_en),
    .stage_flush (stage_flush),
    .multi_idx   (multi_idx),
    .multi_busy  (multi_busy)
`ifdef PIPE_STAGE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: the controller presents a vector every cycle; compare one per negedge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a = '{pc: pc_we, en: stage_en, fl: stage_flush, idx: multi_idx, busy: multi_busy};
      checks++;
      if (a === e) passes++;
      else
        $display("FAIL vec%0d: got pc_we=%b en=%b flush=%b idx=%0d busy=%b, want pc_we=%b en=%b flush=%b idx=%0d busy=%b",
                 checks, a.pc, a.en, a.fl, a.idx, a.busy, e.pc, e.en, e.fl, e.idx, e.busy);
    end
  end

  // Drive one cycle of inputs (at posedge+1) and queue the expected outputs
  task automatic cyc(input logic r, input logic mb, input logic bf, input logic lu,
                     input logic mr, input logic [3:0] mc,
                     input logic e_pc, input logic [4:0] e_en, input logic [4:0] e_fl,
                     input logic [2:0] e_idx, input logic e_busy);
    rst = r; mem_busy = mb; br_flush = bf; ld_use_haz = lu;
    multi_req = mr; multi_cnt = mc;
    q.push_back('{pc: e_pc, en: e_en, fl: e_fl, idx: e_idx, busy: e_busy});
    if (r && !e_pc) exp_stall++;
    if (r && bf && !mb) exp_flush++;
    vec_no++;
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; mem_busy = 1'b0; br_flush = 1'b0; ld_use_haz = 1'b0;
    multi_req = 1'b0; multi_cnt = 4'd0;
    @(posedge clk);
    #1;
    // Reset values
    cyc(0,0,0,0,0,4'd0, 0,EN_0,FL_RST,0,0);
    cyc(0,0,0,0,1,4'd4, 0,EN_0,FL_RST,0,0);
    // Release, no events
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Branch flush one cycle
    cyc(1,0,1,0,0,4'd0, 1,EN_ALL,FL_BR,0,0);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Load-use bubble
    cyc(1,0,0,1,0,4'd0, 0,EN_LU,FL_LU,0,0);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Priority: mem_busy over br_flush, br_flush over ld_use
    cyc(1,1,1,1,0,4'd0, 0,EN_0,FL_0,0,0);
    cyc(1,0,1,1,1,4'd4, 1,EN_ALL,FL_BR,0,0);
    // LM/SM count 4, multi_req held high inside MULTI (ignored)
    cyc(1,0,0,0,1,4'd4, 0,EN_MUL,FL_0,0,0);
    cyc(1,0,0,0,1,4'd4, 0,EN_MUL,FL_0,1,1);
    cyc(1,0,0,0,1,4'd4, 0,EN_MUL,FL_0,2,1);
    cyc(1,0,0,0,1,4'd4, 1,EN_ALL,FL_0,3,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Count 1 and 0 are plain instructions
    cyc(1,0,0,0,1,4'd1, 1,EN_ALL,FL_0,0,0);
    cyc(1,0,0,0,1,4'd0, 1,EN_ALL,FL_0,0,0);
    // Branch aborts LM/SM at idx 1
    cyc(1,0,0,0,1,4'd4, 0,EN_MUL,FL_0,0,0);
    cyc(1,0,1,0,0,4'd0, 1,EN_ALL,FL_BR,1,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // mem_busy 3 cycles at idx 2, then resume
    cyc(1,0,0,0,1,4'd4, 0,EN_MUL,FL_0,0,0);
    cyc(1,0,0,0,0,4'd0, 0,EN_MUL,FL_0,1,1);
    cyc(1,1,0,0,0,4'd0, 0,EN_0,FL_0,2,1);
    cyc(1,1,0,0,0,4'd0, 0,EN_0,FL_0,2,1);
    cyc(1,1,1,0,0,4'd0, 0,EN_0,FL_0,2,1);
    cyc(1,0,0,0,0,4'd0, 0,EN_MUL,FL_0,2,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,3,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Load-use inside MULTI holds index
    cyc(1,0,0,0,1,4'd3, 0,EN_MUL,FL_0,0,0);
    cyc(1,0,0,1,0,4'd0, 0,EN_LU,FL_LU,1,1);
    cyc(1,0,0,0,0,4'd0, 0,EN_MUL,FL_0,1,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,2,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Count 15 saturates to 8: idx 0..7, release on 7
    cyc(1,0,0,0,1,4'd15, 0,EN_MUL,FL_0,0,0);
    for (int i = 1; i < 7; i++)
      cyc(1,0,0,0,0,4'd0, 0,EN_MUL,FL_0,3'(i),1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,7,1);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    // Async reset mid-MULTI
    cyc(1,0,0,0,1,4'd4, 0,EN_MUL,FL_0,0,0);
    cyc(1,0,0,0,0,4'd0, 0,EN_MUL,FL_0,1,1);
    cyc(0,0,0,0,0,4'd0, 0,EN_0,FL_RST,0,0);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);
    cyc(1,0,0,0,0,4'd0, 1,EN_ALL,FL_0,0,0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending vectors, want 0", q.size());
    end
`ifdef PIPE_STAGE_CTRL_PERF_EN
    checks++;
    if (stall_cycles === 16'(exp_stall)) passes++;
    else $display("FAIL stall_cycles: got %0d, want %0d", stall_cycles, exp_stall);
    checks++;
    if (flush_events === 16'(exp_flush)) passes++;
    else $display("FAIL flush_events: got %0d, want %0d", flush_events, exp_flush);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
